// File: rtl/systolic_tile_sequencer.sv
// Per-tile controller: clear, stationary-load, stream, skew-flush and drain of one PE-array tile.
// Optional stall counter is built when SEQ_PERF_CNT_EN is defined; otherwise stall_cnt reads 0.
module systolic_tile_sequencer #(
  parameter int ARRAY_SIZE = 128,
  parameter int K_WIDTH    = 16,
  parameter int ROW_W      = $clog2(ARRAY_SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_len,
  input  logic               os_mode,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err_zero_k,
  output logic               wload_req,
  output logic [ROW_W-1:0]   wload_row,
  input  logic               wload_ack,
  output logic               act_req,
  input  logic               act_valid,
  output logic               feed_zero,
  output logic               mac_enable,
  output logic               accum_clear,
  output logic               output_stationary_enable,
  output logic               res_valid,
  output logic [ROW_W-1:0]   res_row,
  input  logic               res_ready,
  output logic [31:0]        stall_cnt,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ARRAY_SIZE - 1);
  localparam logic [ROW_W:0]   FLUSH_LAST = (ROW_W + 1)'(2 * ARRAY_SIZE - 3);

  state_t             state;
  logic [K_WIDTH-1:0] k_q;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [ROW_W:0]     flush_cnt;

  assign fsm_state = state;

  // act_req is registered; a beat is consumed in exactly the cycle act_valid answers it.
  assign mac_enable = feed_zero | (act_req & act_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                    <= S_IDLE;
      k_q                      <= '0;
      beat_cnt                 <= '0;
      flush_cnt                <= '0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
      err_zero_k               <= 1'b0;
      wload_req                <= 1'b0;
      wload_row                <= '0;
      act_req                  <= 1'b0;
      feed_zero                <= 1'b0;
      accum_clear              <= 1'b0;
      output_stationary_enable <= 1'b0;
      res_valid                <= 1'b0;
      res_row                  <= '0;
    end else begin
      done        <= 1'b0;
      err_zero_k  <= 1'b0;
      accum_clear <= 1'b0;
      if (abort && state != S_IDLE && state != S_DONE) begin
        state                    <= S_IDLE;
        busy                     <= 1'b0;
        accum_clear              <= 1'b1;
        wload_req                <= 1'b0;
        wload_row                <= '0;
        act_req                  <= 1'b0;
        feed_zero                <= 1'b0;
        res_valid                <= 1'b0;
        res_row                  <= '0;
        output_stationary_enable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            k_q                      <= k_len;
            output_stationary_enable <= os_mode;
            busy                     <= 1'b1;
            accum_clear              <= 1'b1;
            state                    <= S_CLEAR;
          end
          S_CLEAR: begin
            if (k_q == '0) begin
              done       <= 1'b1;
              err_zero_k <= 1'b1;
              state      <= S_DONE;
            end else if (output_stationary_enable) begin
              act_req  <= 1'b1;
              beat_cnt <= '0;
              state    <= S_COMPUTE;
            end else begin
              wload_req <= 1'b1;
              wload_row <= '0;
              state     <= S_LOAD;
            end
          end
          S_LOAD: if (wload_ack) begin
            if (wload_row == LAST_ROW) begin
              wload_req <= 1'b0;
              wload_row <= '0;
              act_req   <= 1'b1;
              beat_cnt  <= '0;
              state     <= S_COMPUTE;
            end else begin
              wload_row <= wload_row + ROW_W'(1);
            end
          end
          S_COMPUTE: if (act_valid) begin
            // Compare against k_len-1 so k_len = all-ones never needs a wider counter.
            if (beat_cnt == k_q - K_WIDTH'(1)) begin
              act_req   <= 1'b0;
              feed_zero <= 1'b1;
              flush_cnt <= '0;
              state     <= S_FLUSH;
            end else begin
              beat_cnt <= beat_cnt + K_WIDTH'(1);
            end
          end
          S_FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              feed_zero <= 1'b0;
              if (output_stationary_enable) begin
                res_valid <= 1'b1;
                res_row   <= '0;
                state     <= S_DRAIN;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              flush_cnt <= flush_cnt + (ROW_W + 1)'(1);
            end
          end
          S_DRAIN: if (res_ready) begin
            if (res_row == LAST_ROW) begin
              res_valid <= 1'b0;
              res_row   <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              res_row <= res_row + ROW_W'(1);
            end
          end
          S_DONE: begin
            busy                     <= 1'b0;
            output_stationary_enable <= 1'b0;
            state                    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state == S_IDLE && start) begin
      stall_q <= '0;
    end else if (((state == S_COMPUTE && !act_valid) || (state == S_DRAIN && !res_ready))
                 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
